// File: rtl/match_pattern_tx_pkg.sv
// rtl/match_pattern_tx_pkg.sv - shared constants for the pattern transmitter and match_filter
package match_pattern_tx_pkg;

  // Pattern geometry shared with match_filter so both ends agree on length.
  localparam int MF_NUM_WORDS      = 7;
  localparam int MF_CHIPS_PER_WORD = 32;

  // Default magnitude of a chip on the I rail.
  localparam logic [15:0] MF_AMPLITUDE = 16'h4000;

  // Frame state encoding.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_PAYLOAD  = 2'd2;

  // Map a chip bit to a signed sample: 1 -> +amp, 0 -> -amp (two's complement).
  function automatic logic [15:0] chip_level(input logic chip, input logic [15:0] amp);
    return chip ? amp : (~amp + 16'd1);
  endfunction

endpackage

// File: rtl/match_pattern_regs.sv
// rtl/match_pattern_regs.sv - pattern word register file with write lock and chip read port
module match_pattern_regs
  import match_pattern_tx_pkg::*;
#(
  parameter int NUM_WORDS = MF_NUM_WORDS,
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   cdata,
  input  logic [2:0]    cstate,
  input  logic          cwrite,
  input  logic          lock,
  input  logic [WW-1:0] rd_word,
  input  logic [4:0]    rd_chip,
  output logic          chip
);

  logic [31:0] words [NUM_WORDS];

  // Word write: cstate is 1-based, so 0 and out-of-range addresses match nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        words[w] <= '0;
      end
    end else if (cwrite && !lock) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (int'(cstate) == w + 1) begin
          words[w] <= cdata;
        end
      end
    end
  end

  // Chip read: chip index 0 is the word MSB, so the bit select is 31 - rd_chip (= ~rd_chip).
  always_comb begin
    chip = 1'b0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (int'(rd_word) == w) begin
        chip = words[w][~rd_chip];
      end
    end
  end

endmodule

// File: rtl/match_pattern_tx.sv
// rtl/match_pattern_tx.sv - emits the programmed chip pattern, then forwards payload samples
module match_pattern_tx
  import match_pattern_tx_pkg::*;
#(
  parameter int          NUM_WORDS = MF_NUM_WORDS,
  parameter logic [15:0] AMPLITUDE = MF_AMPLITUDE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        txstrobe,
  input  logic [31:0] cdata,
  input  logic [2:0]  cstate,
  input  logic        cwrite,
  input  logic        start,
  input  logic [15:0] data_i,
  input  logic [15:0] data_q,
  input  logic        data_last,
  output logic        data_req,
  output logic [15:0] tx_i,
  output logic [15:0] tx_q,
  output logic        busy,
  output logic        preamble_active,
  output logic        done
);

  localparam int NCHIPS = NUM_WORDS * MF_CHIPS_PER_WORD;
  localparam int CW     = $clog2(NCHIPS);
  localparam int WW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [1:0]    state;
  logic [CW-1:0] counter;
  logic          chip;
  logic          last_chip;

  // The pattern is locked whenever a frame is in flight.
  match_pattern_regs #(
    .NUM_WORDS (NUM_WORDS)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .cdata   (cdata),
    .cstate  (cstate),
    .cwrite  (cwrite),
    .lock    (state != ST_IDLE),
    .rd_word (WW'(counter >> 5)),
    .rd_chip (counter[4:0]),
    .chip    (chip)
  );

  assign last_chip       = (counter == CW'(NCHIPS - 1));
  assign data_req        = (state == ST_PAYLOAD) && txstrobe;
  assign busy            = (state != ST_IDLE);
  assign preamble_active = (state == ST_PREAMBLE);

  // Frame sequencer: one chip or payload sample per txstrobe, registered onto tx_i/tx_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      tx_i    <= '0;
      tx_q    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (txstrobe) begin
            tx_i <= '0;
            tx_q <= '0;
          end
          if (start) begin
            state   <= ST_PREAMBLE;
            counter <= '0;
          end
        end
        ST_PREAMBLE: begin
          if (txstrobe) begin
            tx_i <= chip_level(chip, AMPLITUDE);
            tx_q <= '0;
            // Counter parks at the terminal chip instead of wrapping; IDLE re-zeroes it.
            if (last_chip) begin
              state <= ST_PAYLOAD;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (txstrobe) begin
            tx_i <= data_i;
            tx_q <= data_q;
            if (data_last) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_pattern_tx.sv
// tb/tb_match_pattern_tx.sv - directed self-checking bench for match_pattern_tx
module tb_match_pattern_tx;
  import match_pattern_tx_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        txstrobe;
  logic [31:0] cdata;
  logic [2:0]  cstate;
  logic        cwrite;
  logic        start;
  logic [15:0] data_i;
  logic [15:0] data_q;
  logic        data_last;
  logic        data_req;
  logic [15:0] tx_i;
  logic [15:0] tx_q;
  logic        busy;
  logic        preamble_active;
  logic        done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  cs;
    logic [31:0] d;
  } load_vec_t;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
  } pay_t;

  load_vec_t lv [10];
  pay_t      ps [3];

  logic [6:0][31:0] pat_a;
  logic [6:0][31:0] pat_b;
  logic [6:0][31:0] pat_zero;

  match_pattern_tx dut (
    .clk             (clk),
    .reset           (reset),
    .txstrobe        (txstrobe),
    .cdata           (cdata),
    .cstate          (cstate),
    .cwrite          (cwrite),
    .start           (start),
    .data_i          (data_i),
    .data_q          (data_q),
    .data_last       (data_last),
    .data_req        (data_req),
    .tx_i            (tx_i),
    .tx_q            (tx_q),
    .busy            (busy),
    .preamble_active (preamble_active),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [2:0] cs, input logic [31:0] d);
    cwrite = 1'b1;
    cstate = cs;
    cdata  = d;
    tick();
    cwrite = 1'b0;
  endtask

  task automatic strobe(output logic dreq);
    txstrobe = 1'b1;
    #1;
    dreq = data_req;
    tick();
    txstrobe = 1'b0;
  endtask

  task automatic run_chips(input logic [6:0][31:0] w, input int first, input int count,
                           input int period);
    logic        dr;
    logic [15:0] exp;
    for (int c = first; c < first + count; c++) begin
      check($sformatf("pre_active_c%0d", c), preamble_active, 1);
      strobe(dr);
      check("pre_dreq", dr, 0);
      exp = w[c / 32][31 - (c % 32)] ? 16'h4000 : 16'hC000;
      check($sformatf("chip%0d_i", c), tx_i, exp);
      check($sformatf("chip%0d_q", c), tx_q, 0);
      if (period > 1) begin
        idle(period - 1);
        check($sformatf("chip%0d_hold", c), tx_i, exp);
      end
    end
  endtask

  task automatic send_payload(input int n, input int period);
    logic dr;
    for (int k = 0; k < n; k++) begin
      data_i    = ps[k].i;
      data_q    = ps[k].q;
      data_last = (k == n - 1);
      strobe(dr);
      check($sformatf("pay%0d_dreq", k), dr, 1);
      check($sformatf("pay%0d_i", k), tx_i, ps[k].i);
      check($sformatf("pay%0d_q", k), tx_q, ps[k].q);
      check($sformatf("pay%0d_done", k), done, (k == n - 1) ? 1 : 0);
      check($sformatf("pay%0d_busy", k), busy, (k == n - 1) ? 0 : 1);
      data_last = 1'b0;
      if (k != n - 1 && period > 1) begin
        idle(period - 1);
        check("pay_gap_dreq", data_req, 0);
      end
    end
  endtask

  initial begin
    lv[0] = '{3'd1, 32'hF0F0_1234};
    lv[1] = '{3'd2, 32'hDEAD_BEEF};
    lv[2] = '{3'd0, 32'hFFFF_FFFF};
    lv[3] = '{3'd3, 32'h0000_0001};
    lv[4] = '{3'd4, 32'h8000_0000};
    lv[5] = '{3'd5, 32'hAAAA_5555};
    lv[6] = '{3'd6, 32'h0F0F_F0F0};
    lv[7] = '{3'd7, 32'h1357_9BDF};
    lv[8] = '{3'd2, 32'hCAFE_F00D};
    lv[9] = '{3'd0, 32'h0000_0000};
    pat_b = {32'h1357_9BDF, 32'h0F0F_F0F0, 32'hAAAA_5555, 32'h8000_0000,
             32'h0000_0001, 32'hCAFE_F00D, 32'hF0F0_1234};
    pat_a    = {192'h0, 32'h8000_0000};
    pat_zero = '0;
    ps[0] = '{16'h1111, 16'h2222};
    ps[1] = '{16'h3333, 16'h4444};
    ps[2] = '{16'h5555, 16'h6666};

    reset     = 1'b0;
    txstrobe  = 1'b0;
    cdata     = '0;
    cstate    = '0;
    cwrite    = 1'b0;
    start     = 1'b0;
    data_i    = '0;
    data_q    = '0;
    data_last = 1'b0;
    idle(3);
    check("rst_tx_i", tx_i, 0);
    check("rst_tx_q", tx_q, 0);
    check("rst_busy", busy, 0);
    check("rst_pre", preamble_active, 0);
    check("rst_done", done, 0);
    check("rst_dreq", data_req, 0);
    reset = 1'b1;
    tick();

    // Single-one pattern, strobe every 16 clocks, three-sample payload.
    load(3'd1, 32'h8000_0000);
    for (int cs = 2; cs <= 7; cs++) load(3'(cs), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_busy", busy, 1);
    check("a_pre", preamble_active, 1);
    check("a_tx_before", tx_i, 0);
    run_chips(pat_a, 0, 224, 16);
    check("a_pre_end", preamble_active, 0);
    check("a_busy_pay", busy, 1);
    send_payload(3, 16);
    tick();
    check("a_done_pulse", done, 0);
    check("a_busy_after", busy, 0);

    // Table-driven load including ignored cstate=0, locked write mid-preamble.
    foreach (lv[k]) load(lv[k].cs, lv[k].d);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_chips(pat_b, 0, 5, 2);
    load(3'd3, 32'hFFFF_FFFF);
    run_chips(pat_b, 5, 219, 2);
    send_payload(1, 2);

    // Start coincident with a strobe: that strobe zeroes tx, chip 0 comes next.
    start    = 1'b1;
    txstrobe = 1'b1;
    tick();
    txstrobe = 1'b0;
    check("co_tx_i", tx_i, 0);
    check("co_pre", preamble_active, 1);
    run_chips(pat_b, 0, 224, 2);
    send_payload(1, 2);
    tick();
    check("b2b_busy", busy, 1);
    check("b2b_pre", preamble_active, 1);
    check("b2b_done", done, 0);
    start = 1'b0;

    // Asynchronous reset at chip 100 of the back-to-back frame.
    run_chips(pat_b, 0, 100, 2);
    #2;
    reset = 1'b0;
    #1;
    check("ar_tx_i", tx_i, 0);
    check("ar_tx_q", tx_q, 0);
    check("ar_busy", busy, 0);
    check("ar_pre", preamble_active, 0);
    check("ar_done", done, 0);
    tick();
    reset = 1'b1;
    tick();

    // Pattern was cleared by reset: every chip is negative.
    start = 1'b1;
    tick();
    start = 1'b0;
    run_chips(pat_zero, 0, 224, 1);
    send_payload(1, 1);

    // Reload and confirm the frame restarts from chip 0.
    foreach (lv[k]) load(lv[k].cs, lv[k].d);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_chips(pat_b, 0, 224, 1);
    send_payload(3, 1);
    tick();
    check("end_done", done, 0);
    check("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_pattern_tx.md
Name: match_pattern_tx

Overview:
- Transmit-side counterpart of match_filter: emits the same 7×32-chip pattern match_filter correlates against, then passes payload samples.
- Pattern is loaded over the same cdata/cstate/cwrite interface match_filter uses, so one host write sequence programs both ends.
- Sits in the TX path ahead of the interpolator; advances one chip per txstrobe.

Parameters:
- NUM_WORDS, 7, number of 32-bit pattern words; pattern length is NUM_WORDS*32 chips.
- AMPLITUDE, 16'h4000, magnitude of each chip on the I output.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- txstrobe  in  1  one-cycle sample strobe from strobe_gen
- cdata  in  32  pattern word
- cstate  in  3  word address, 1..NUM_WORDS; 0 is ignored
- cwrite  in  1  write enable for cdata at cstate
- start  in  1  request to send one pattern followed by payload
- data_i  in  16  payload I sample
- data_q  in  16  payload Q sample
- data_last  in  1  marks the final payload sample, qualified by data_req
- data_req  out  1  combinational; high when state==PAYLOAD && txstrobe, and data_i/q are consumed that cycle
- tx_i  out  16  registered I sample
- tx_q  out  16  registered Q sample
- busy  out  1  state != IDLE
- preamble_active  out  1  state == PREAMBLE
- done  out  1  one-cycle pulse after the last payload sample is registered

Behaviour:
- Reset (reset low, async):
  - state=IDLE; chip counter=0.
  - All pattern words=0; tx_i=tx_q=0; done=0.
- Pattern load:
  - When cwrite=1, state==IDLE and cstate in 1..NUM_WORDS, word[cstate-1] <= cdata on clk.
  - cstate=0 or cstate>NUM_WORDS: write ignored.
  - cwrite while busy: write ignored; the pattern is stable for the whole frame.
- FSM IDLE:
  - start=1 -> PREAMBLE, counter <= 0.
  - A txstrobe in the same cycle as start is not used for a chip; the first chip goes out on the next strobe.
  - On txstrobe: tx_i <= 0, tx_q <= 0.
- FSM PREAMBLE, on txstrobe:
  - Chip = word[counter>>5] bit (31 - counter[4:0]): word 0 first, MSB first.
  - tx_i <= chip ? AMPLITUDE : -AMPLITUDE (two's complement); tx_q <= 0; counter++.
  - When counter == NUM_WORDS*32-1 on a strobe -> PAYLOAD.
  - No strobe: outputs and counter hold.
  - start is ignored.
- FSM PAYLOAD, on txstrobe:
  - data_req=1; tx_i <= data_i; tx_q <= data_q.
  - If data_last=1 -> IDLE and done=1 on the next cycle.
  - Zero-length payload is not possible: at least one payload sample is always sent.
- Output timing:
  - tx_i/tx_q update on the clk edge that samples txstrobe; latency is 1 clk from strobe.
  - Values hold between strobes.
- Counter width: $clog2(NUM_WORDS*32) bits; never wraps, because the state exits at the terminal count.
- start held high continuously: a new frame begins on the cycle after done, i.e. back-to-back frames.
- Reset mid-frame: immediate return to IDLE with outputs 0; the pattern is cleared and must be reloaded.

Decomposition:
- Shared package (also used by match_filter and its bench):
  - MF_NUM_WORDS=7, MF_CHIPS_PER_WORD=32.
  - Default AMPLITUDE.
  - State encoding for IDLE/PREAMBLE/PAYLOAD.
- One sub-module, match_pattern_regs:
  - NUM_WORDS×32 register file with cstate decode and write-lock input.
  - 5-bit chip-select read port returning the single chip bit.

Test Plan:
- Load word0=32'h8000_0000, words1..6=0; start; strobe every 16 clk via strobe_gen:
  - first tx_i=16'h4000, next 223 strobes tx_i=16'hC000, tx_q=0 throughout.
  - preamble_active high for exactly 224 strobes.
- Load words from tx_cs.dat; send; feed tx_i sign bits into match_filter via loopback -> match asserts exactly once at preamble end.
- Payload of 3 samples (0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666 with data_last on the third):
  - data_req pulses 3 times; tx outputs track the samples; done one cycle after the third; busy drops the same cycle.
- cwrite with cstate=3 during PREAMBLE, and a cwrite with cstate=0 in IDLE -> pattern unchanged; the second frame emits the identical chip sequence.
- reset driven low at chip 100 -> tx_i=0, busy=0 within that cycle asynchronously; after reload and start the frame restarts from chip 0.
- start coincident with txstrobe in IDLE -> no chip on that strobe; chip 0 on the following strobe.
